// File: rtl/vclk_pkg.sv
// Shared definitions for the video-clock reset sequencer: state encoding,
// default timing parameters and a saturating counter helper.
package vclk_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_RUN       = 2'd2,
      ST_HOLD      = 2'd3
   } vclk_state_e;

   localparam int unsigned LOCK_STABLE_CYCLES_DEF = 1024;
   localparam int unsigned HOLD_CYCLES_DEF        = 256;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      if (val == 8'hFF) begin
         sat_inc8 = 8'hFF;
      end else begin
         sat_inc8 = val + 8'd1;
      end
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by
// the block reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Capture flop followed by the resolving flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/vclk_reset_seq.sv
// Video-clock reset sequencer: holds the video domain in reset until the PLL
// lock has been stable long enough, and re-enters reset on lock loss/restart.
module vclk_reset_seq
   import vclk_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
   parameter int unsigned HOLD_CYCLES        = HOLD_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       rst_out,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] loss_count
);

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

   logic        w_lock_s;
   vclk_state_e r_state;
   vclk_state_e w_state_nx;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nx;
   logic [7:0]  r_loss;
   logic [7:0]  w_loss_nx;
   logic        r_rst_out;
   logic        r_ready;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (pll_lock),
      .o_q   (w_lock_s)
   );

   // Next-state, counter and loss-count logic.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_loss_nx  = r_loss;
      case (r_state)
         ST_WAIT_LOCK: begin
            w_cnt_nx = 16'd0;
            if (w_lock_s) begin
               w_state_nx = ST_STABLE;
            end else begin
               w_state_nx = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!w_lock_s) begin
               w_state_nx = ST_WAIT_LOCK;
               w_cnt_nx   = 16'd0;
            end else if (r_cnt == LOCK_LAST) begin
               w_state_nx = ST_RUN;
               w_cnt_nx   = 16'd0;
            end else begin
               w_cnt_nx = r_cnt + 16'd1;
            end
         end
         ST_RUN: begin
            // Lock loss takes priority so a coincident restart counts once.
            if (!w_lock_s) begin
               w_state_nx = ST_HOLD;
               w_cnt_nx   = 16'd0;
               w_loss_nx  = sat_inc8(r_loss);
            end else if (restart) begin
               w_state_nx = ST_HOLD;
               w_cnt_nx   = 16'd0;
            end else begin
               w_state_nx = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_state_nx = ST_WAIT_LOCK;
               w_cnt_nx   = 16'd0;
            end else begin
               w_cnt_nx = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = 16'd0;
         end
      endcase
   end

   // State, counters and glitch-free outputs decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_WAIT_LOCK;
         r_cnt     <= 16'd0;
         r_loss    <= 8'd0;
         r_rst_out <= 1'b1;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_loss    <= w_loss_nx;
         r_rst_out <= (w_state_nx != ST_RUN);
         r_ready   <= (w_state_nx == ST_RUN);
      end
   end

   assign rst_out    = r_rst_out;
   assign ready      = r_ready;
   assign state      = r_state;
   assign loss_count = r_loss;

endmodule

// File: tb/tb_vclk_reset_seq.sv
// Directed scoreboard bench for vclk_reset_seq with short timing parameters.
module tb_vclk_reset_seq;

   logic       clk;
   logic       reset;
   logic       pll_lock;
   logic       restart;
   logic       rst_out;
   logic       ready;
   logic [1:0] state;
   logic [7:0] loss_count;

   typedef struct {
      string       tag;
      logic [11:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;
   logic [7:0] exp_loss;

   vclk_reset_seq #(
      .LOCK_STABLE_CYCLES (8),
      .HOLD_CYCLES        (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .rst_out    (rst_out),
      .ready      (ready),
      .state      (state),
      .loss_count (loss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] pk(input logic [1:0] st, input logic ro,
                                      input logic rd, input logic [7:0] l);
      pk = {st, ro, rd, l};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Push the expectation, advance n edges, then pop and compare.
   task automatic step(input int n, input string tag, input logic [1:0] st,
                       input logic ro, input logic rd, input logic [7:0] l);
      exp_t e;
      exp_t got;
      logic [11:0] obs;
      e.tag = tag;
      e.val = pk(st, ro, rd, l);
      exp_q.push_back(e);
      tick(n);
      got = exp_q.pop_front();
      obs = {state, rst_out, ready, loss_count};
      total++;
      assert (obs === got.val) else begin
         bad++;
         $error("FAIL %s observed st=%0d rst=%0b rdy=%0b loss=%0d expected st=%0d rst=%0b rdy=%0b loss=%0d",
                got.tag, obs[11:10], obs[9], obs[8], obs[7:0],
                got.val[11:10], got.val[9], got.val[8], got.val[7:0]);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;
      #2;
      step(0, "reset_state", 2'd0, 1'b1, 1'b0, 8'd0);
      tick(1);
      reset = 1'b0;
      step(3, "wait_no_lock", 2'd0, 1'b1, 1'b0, 8'd0);

      // Lock acquisition latency: release at edge 11.
      pll_lock = 1'b1;
      step(2, "acq_sync_e2", 2'd0, 1'b1, 1'b0, 8'd0);
      step(1, "acq_stable_e3", 2'd1, 1'b1, 1'b0, 8'd0);
      step(7, "acq_stable_e10", 2'd1, 1'b1, 1'b0, 8'd0);
      step(1, "acq_run_e11", 2'd2, 1'b0, 1'b1, 8'd0);

      // Lock loss in RUN.
      pll_lock = 1'b0;
      step(2, "loss_e2_run", 2'd2, 1'b0, 1'b1, 8'd0);
      step(1, "loss_e3_hold", 2'd3, 1'b1, 1'b0, 8'd1);
      step(3, "loss_hold_end", 2'd3, 1'b1, 1'b0, 8'd1);
      step(1, "loss_wait", 2'd0, 1'b1, 1'b0, 8'd1);
      pll_lock = 1'b1;
      step(10, "relock_stable", 2'd1, 1'b1, 1'b0, 8'd1);
      step(1, "relock_run", 2'd2, 1'b0, 1'b1, 8'd1);

      // Restart with steady lock; restarts in HOLD/STABLE are ignored.
      restart = 1'b1;
      step(1, "restart_hold", 2'd3, 1'b1, 1'b0, 8'd1);
      step(1, "restart_in_hold", 2'd3, 1'b1, 1'b0, 8'd1);
      restart = 1'b0;
      step(2, "restart_hold_end", 2'd3, 1'b1, 1'b0, 8'd1);
      step(1, "restart_wait", 2'd0, 1'b1, 1'b0, 8'd1);
      step(1, "restart_stable", 2'd1, 1'b1, 1'b0, 8'd1);
      restart = 1'b1;
      step(1, "restart_in_stable", 2'd1, 1'b1, 1'b0, 8'd1);
      restart = 1'b0;
      step(6, "restart_stable_end", 2'd1, 1'b1, 1'b0, 8'd1);
      step(1, "restart_run", 2'd2, 1'b0, 1'b1, 8'd1);

      // Restart coincident with lock_s falling counts one loss.
      pll_lock = 1'b0;
      step(2, "coinc_pre", 2'd2, 1'b0, 1'b1, 8'd1);
      restart = 1'b1;
      step(1, "coinc_hold", 2'd3, 1'b1, 1'b0, 8'd2);
      restart = 1'b0;
      step(3, "coinc_hold_end", 2'd3, 1'b1, 1'b0, 8'd2);
      step(1, "coinc_wait", 2'd0, 1'b1, 1'b0, 8'd2);

      // Short lock glitch during STABLE restarts qualification.
      pll_lock = 1'b1;
      step(5, "glitch_stable", 2'd1, 1'b1, 1'b0, 8'd2);
      pll_lock = 1'b0;
      step(2, "glitch_still_stable", 2'd1, 1'b1, 1'b0, 8'd2);
      step(1, "glitch_wait", 2'd0, 1'b1, 1'b0, 8'd2);
      pll_lock = 1'b1;
      step(10, "glitch_requal", 2'd1, 1'b1, 1'b0, 8'd2);
      step(1, "glitch_run", 2'd2, 1'b0, 1'b1, 8'd2);

      // 300 lock-loss events; lock returns during HOLD and is ignored there.
      exp_loss = 8'd2;
      for (int i = 0; i < 300; i++) begin
         exp_loss = (exp_loss == 8'hFF) ? 8'hFF : exp_loss + 8'd1;
         pll_lock = 1'b0;
         step(3, "sat_hold", 2'd3, 1'b1, 1'b0, exp_loss);
         pll_lock = 1'b1;
         step(13, "sat_run", 2'd2, 1'b0, 1'b1, exp_loss);
      end
      step(0, "sat_255", 2'd2, 1'b0, 1'b1, 8'd255);

      // Async reset pulse mid-STABLE.
      pll_lock = 1'b0;
      step(3, "ar_hold", 2'd3, 1'b1, 1'b0, 8'd255);
      step(4, "ar_wait", 2'd0, 1'b1, 1'b0, 8'd255);
      pll_lock = 1'b1;
      step(3, "ar_stable", 2'd1, 1'b1, 1'b0, 8'd255);
      #1;
      reset = 1'b1;
      #1;
      step(0, "ar_async", 2'd0, 1'b1, 1'b0, 8'd0);
      #1;
      reset = 1'b0;
      step(10, "ar_requal", 2'd1, 1'b1, 1'b0, 8'd0);
      step(1, "ar_run", 2'd2, 1'b0, 1'b1, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vclk_reset_seq.md
VCLK_RESET_SEQ -- requirements
Module: vclk_reset_seq

Interface
REQ-001 Parameter: LOCK_STABLE_CYCLES, default 1024; consecutive synchronized-lock cycles required before reset release; legal range 2..65535.
REQ-002 Parameter: HOLD_CYCLES, default 256; minimum reset-hold cycles after lock loss or restart; legal range 2..65535.
REQ-003 Port: clk  input  1  PLL reference clock (24 MHz crystal clock, never the PLL output); all logic clocked on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high block reset.
REQ-005 Port: pll_lock  input  1  PLL LOCK output; asynchronous to clk.
REQ-006 Port: restart  input  1  synchronous single-cycle request to force a reset sequence.
REQ-007 Port: rst_out  output  1  active-high reset for the video-clock domain; registered.
REQ-008 Port: ready  output  1  high only in RUN state; registered.
REQ-009 Port: state  output  2  current state encoding: WAIT_LOCK=0, STABLE=1, RUN=2, HOLD=3.
REQ-010 Port: loss_count  output  8  count of lock losses while in RUN; saturates at 255.

Function
REQ-011 pll_lock SHALL pass through a 2-flop synchronizer; lock_s denotes the synchronizer output, valid 2 edges after a pll_lock change.
REQ-012 WAIT_LOCK: lock_s=1 -> STABLE, with the 16-bit counter cleared to 0; otherwise remain.
REQ-013 STABLE: each cycle with lock_s=1, the counter increments; lock_s=1 and counter==LOCK_STABLE_CYCLES-1 -> RUN; lock_s=0 -> WAIT_LOCK with the counter cleared and loss_count unchanged.
REQ-014 RUN: lock_s=0 -> HOLD, counter cleared, loss_count+1 (saturating); restart=1 with lock_s=1 -> HOLD, counter cleared, loss_count unchanged.
REQ-015 In RUN, simultaneous lock_s=0 and restart=1 SHALL increment loss_count exactly once.
REQ-016 HOLD: the counter increments every cycle regardless of lock_s; counter==HOLD_CYCLES-1 -> WAIT_LOCK; pll_lock and restart are ignored while in HOLD.
REQ-017 restart SHALL be ignored in WAIT_LOCK, STABLE and HOLD.
REQ-018 rst_out SHALL be 0 exactly while state==RUN; rst_out and ready update on the same edge as the state transition and never glitch.
REQ-019 Latency: with pll_lock rising and staying high, rst_out falls on the (LOCK_STABLE_CYCLES+3)-th clk edge after the rise is first sampled.
REQ-020 Latency: pll_lock falling in RUN SHALL raise rst_out on the 3rd clk edge after the fall is first sampled.
REQ-021 After entering HOLD, rst_out SHALL stay high for at least HOLD_CYCLES+1+LOCK_STABLE_CYCLES cycles.

Reset
REQ-022 reset=1 SHALL asynchronously force: state=WAIT_LOCK, counter=0, synchronizer flops=0, rst_out=1, ready=0, loss_count=0.
REQ-023 reset asserted mid-sequence (any state) SHALL abort the sequence; after deassertion, operation restarts from WAIT_LOCK with a full stable-lock qualification.

Structure
REQ-024 The state encoding constants and the default parameter values SHALL be placed in the shared package vclk_pkg.
REQ-025 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, async active-high reset to 0), instantiated once.

Verification (LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4)
REQ-026 After reset, pll_lock held at 1 -> rst_out falls at edge 11 after sampling; ready=1, state=2.
REQ-027 pll_lock high for 5 cycles, then low, then high -> state returns to WAIT_LOCK, loss_count=0, full 11-edge latency restarts from the second rise.
REQ-028 In RUN, pll_lock drops -> rst_out=1 at edge 3, state=3 for 4 cycles, then state=0; loss_count=1; with lock restored, RUN is re-entered after the STABLE qualification.
REQ-029 In RUN, single restart pulse with lock steady -> HOLD then RUN again; loss_count unchanged; restart same cycle as lock_s falling -> loss_count +1 only.
REQ-030 300 lock-loss events -> loss_count saturates at 255; async reset pulse mid-STABLE -> all outputs return to reset values within the same cycle.
